tcp_rx_tmp_buf_drain: RTL and testbench

Reader side of the RX temporary payload buffer. Pops one store-queue entry per segment: slab number, flow ID, accept flag, and destination address/length. It streams the segment's lines out of the two-slab temp RAM into the per-flow payload buffer, releases the slab, and posts a commit to the RX flow-state logic. It sits between the RX store-buffer queue and the payload-buffer write port.

---
 rtl/tcp_rx_tmp_buf_drain_pkg.sv | 45 ++++
 rtl/tcp_rx_drain_skid.sv | 61 ++++++
 rtl/tcp_rx_tmp_buf_drain.sv | 169 ++++++++++++++++
 tb/tb_tcp_rx_tmp_buf_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_rx_tmp_buf_drain_pkg.sv
// Shared types and sizes for the RX temp-buffer drain path.
// Two 143-line slabs of 64 B lines feed the per-flow payload buffer.
package tcp_rx_tmp_buf_drain_pkg;

  localparam int MAC_INTERFACE_BYTES = 64;
  localparam int MAC_INTERFACE_W = MAC_INTERFACE_BYTES * 8;
  localparam int MAC_PAD_W = $clog2(MAC_INTERFACE_BYTES);

  localparam int RX_TMP_BUF_SLAB_BYTES = 9152;
  localparam int RX_TMP_BUF_SLAB_LINES =
    RX_TMP_BUF_SLAB_BYTES / MAC_INTERFACE_BYTES;
  localparam int RX_TMP_BUF_SLABS = 2;
  localparam int RX_TMP_BUF_SLAB_NUM_W = $clog2(RX_TMP_BUF_SLABS);
  localparam int RX_TMP_BUF_MEM_ADDR_W =
    $clog2(RX_TMP_BUF_SLABS * RX_TMP_BUF_SLAB_LINES);
  localparam int RX_TMP_BUF_LINE_W = $clog2(RX_TMP_BUF_SLAB_LINES + 1);

  localparam int FLOWID_W = 8;
  localparam int PAYLOAD_ENTRY_ADDR_W = 32;
  localparam int PAYLOAD_ENTRY_LEN_W = 16;

  typedef struct packed {
    logic [FLOWID_W-1:0]             flowid;
    logic                            accept_payload;
    logic [PAYLOAD_ENTRY_ADDR_W-1:0] payload_addr;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]  payload_len;
  } rx_store_buf_q_struct;

  localparam int RX_STORE_BUF_Q_STRUCT_W = $bits(rx_store_buf_q_struct);

  typedef struct packed {
    logic [FLOWID_W-1:0]            flowid;
    logic                           accepted;
    logic [PAYLOAD_ENTRY_LEN_W-1:0] payload_len;
  } rx_drain_commit_struct;

  localparam int RX_DRAIN_COMMIT_STRUCT_W = $bits(rx_drain_commit_struct);

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_READ,
    DRAIN_COMMIT
  } drain_state_e;

endpackage

// File: rtl/tcp_rx_drain_skid.sv
// Two-entry FIFO between the temp-RAM return path and the payload-buffer
// write port; the reader's credit count keeps it from overflowing.
module tcp_rx_drain_skid
  import tcp_rx_tmp_buf_drain_pkg::*;
#(
  parameter int DATA_W = MAC_INTERFACE_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_val,
  input  logic [DATA_W-1:0]               in_data,
  input  logic [PAYLOAD_ENTRY_ADDR_W-1:0] in_addr,
  input  logic                            in_last,
  input  logic [MAC_PAD_W-1:0]            in_pad,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [DATA_W-1:0]               out_data,
  output logic [PAYLOAD_ENTRY_ADDR_W-1:0] out_addr,
  output logic                            out_last,
  output logic [MAC_PAD_W-1:0]            out_pad,
  output logic [1:0]                      count
);

  typedef struct packed {
    logic [DATA_W-1:0]               data;
    logic [PAYLOAD_ENTRY_ADDR_W-1:0] addr;
    logic                            last;
    logic [MAC_PAD_W-1:0]            pad;
  } ent_t;

  ent_t       ent [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign push = in_val && (cnt != 2'd2);
  assign pop = out_val && out_rdy;
  assign out_val = (cnt != 2'd0);
  assign count = cnt;
  assign {out_data, out_addr, out_last, out_pad} = ent[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= '{in_data, in_addr, in_last, in_pad};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/tcp_rx_tmp_buf_drain.sv
// Drains one stored segment per store-queue entry from the temp RAM into
// the payload buffer, then commits to flow state and frees the slab.
module tcp_rx_tmp_buf_drain
  import tcp_rx_tmp_buf_drain_pkg::*;
#(
  parameter int DATA_W     = MAC_INTERFACE_W,
  parameter int SLAB_LINES = RX_TMP_BUF_SLAB_LINES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                src_drain_req_val,
  input  logic [RX_STORE_BUF_Q_STRUCT_W-1:0]  src_drain_req,
  input  logic [RX_TMP_BUF_SLAB_NUM_W-1:0]    src_drain_req_slab,
  output logic                                drain_src_req_rdy,
  output logic                                drain_mem_rd_en,
  output logic [RX_TMP_BUF_MEM_ADDR_W-1:0]    drain_mem_rd_addr,
  input  logic [DATA_W-1:0]                   mem_drain_rd_data,
  output logic                                drain_dst_wr_val,
  output logic [PAYLOAD_ENTRY_ADDR_W-1:0]     drain_dst_wr_addr,
  output logic [DATA_W-1:0]                   drain_dst_wr_data,
  output logic                                drain_dst_wr_last,
  output logic [MAC_PAD_W-1:0]                drain_dst_wr_padbytes,
  input  logic                                dst_drain_wr_rdy,
  output logic                                drain_slab_free_val,
  output logic [RX_TMP_BUF_SLAB_NUM_W-1:0]    drain_slab_free_num,
  output logic                                drain_commit_val,
  output logic [RX_DRAIN_COMMIT_STRUCT_W-1:0] drain_commit,
  input  logic                                state_drain_commit_rdy
);

  localparam int BYTES = DATA_W / 8;
  localparam int SLAB_BYTES = SLAB_LINES * BYTES;
  localparam int AW = RX_TMP_BUF_MEM_ADDR_W;
  localparam int LW = RX_TMP_BUF_LINE_W;

  rx_store_buf_q_struct  req;
  drain_state_e          state;
  rx_drain_commit_struct commit_q;

  logic                             src_rdy_q;
  logic                             commit_val_q;
  logic                             inflight;
  logic [RX_TMP_BUF_SLAB_NUM_W-1:0] slab_q;
  logic [AW-1:0]                    base_q;
  logic [LW-1:0]                    lines_q;
  logic [LW-1:0]                    rd_idx;
  logic [LW-1:0]                    ret_idx;
  logic [MAC_PAD_W-1:0]             pad_q;
  logic [PAYLOAD_ENTRY_ADDR_W-1:0]  ret_addr;

  logic                 req_hs;
  logic                 req_ok;
  logic [LW-1:0]        req_lines;
  logic [MAC_PAD_W-1:0] req_pad;
  logic                 rd_en;
  logic [2:0]           owed;
  logic [1:0]           fifo_cnt;
  logic                 ret_last;
  logic                 beat_hs;
  logic                 last_hs;
  logic                 commit_hs;

  assign req = src_drain_req;
  assign req_hs = src_drain_req_val && src_rdy_q;
  assign req_ok = req.accept_payload
               && (req.payload_len != '0)
               && (32'(req.payload_len) <= 32'(SLAB_BYTES));
  assign req_lines =
    LW'((32'(req.payload_len) + 32'(BYTES - 1)) / 32'(BYTES));
  assign req_pad = MAC_PAD_W'(32'(BYTES) - 32'(req.payload_len));

  // Reads in flight plus queued beats, net of the beat leaving this cycle.
  assign owed = 3'(inflight) + 3'(fifo_cnt) - 3'(beat_hs);
  assign rd_en = (state == DRAIN_READ) && (rd_idx < lines_q)
              && (owed < 3'd2);
  assign ret_last = (ret_idx == lines_q - LW'(1));

  assign beat_hs = drain_dst_wr_val && dst_drain_wr_rdy;
  assign last_hs = beat_hs && drain_dst_wr_last;
  assign commit_hs = commit_val_q && state_drain_commit_rdy;

  assign drain_src_req_rdy = src_rdy_q;
  assign drain_mem_rd_en = rd_en;
  assign drain_mem_rd_addr = rd_en ? base_q + AW'(rd_idx) : '0;
  assign drain_slab_free_val = commit_hs;
  assign drain_slab_free_num = slab_q;
  assign drain_commit_val = commit_val_q;
  assign drain_commit = commit_q;

  tcp_rx_drain_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_val   (inflight),
    .in_data  (mem_drain_rd_data),
    .in_addr  (ret_addr),
    .in_last  (ret_last),
    .in_pad   (ret_last ? pad_q : '0),
    .out_val  (drain_dst_wr_val),
    .out_rdy  (dst_drain_wr_rdy),
    .out_data (drain_dst_wr_data),
    .out_addr (drain_dst_wr_addr),
    .out_last (drain_dst_wr_last),
    .out_pad  (drain_dst_wr_padbytes),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DRAIN_IDLE;
      src_rdy_q <= 1'b0;
      commit_val_q <= 1'b0;
      commit_q <= '0;
      inflight <= 1'b0;
      slab_q <= '0;
      base_q <= '0;
      lines_q <= '0;
      pad_q <= '0;
      rd_idx <= '0;
      ret_idx <= '0;
      ret_addr <= '0;
    end else begin
      inflight <= rd_en;
      unique case (state)
        DRAIN_IDLE: begin
          src_rdy_q <= 1'b1;
          if (req_hs) begin
            src_rdy_q <= 1'b0;
            slab_q <= src_drain_req_slab;
            base_q <= AW'(src_drain_req_slab) * AW'(SLAB_LINES);
            lines_q <= req_lines;
            pad_q <= req_pad;
            rd_idx <= '0;
            ret_idx <= '0;
            ret_addr <= req.payload_addr;
            commit_q <= '{req.flowid, req_ok, req.payload_len};
            if (req_ok) begin
              state <= DRAIN_READ;
            end else begin
              state <= DRAIN_COMMIT;
              commit_val_q <= 1'b1;
            end
          end
        end
        DRAIN_READ: begin
          if (rd_en) rd_idx <= rd_idx + LW'(1);
          if (inflight) begin
            ret_idx <= ret_idx + LW'(1);
            ret_addr <= ret_addr + PAYLOAD_ENTRY_ADDR_W'(BYTES);
          end
          if (last_hs) begin
            state <= DRAIN_COMMIT;
            commit_val_q <= 1'b1;
          end
        end
        DRAIN_COMMIT: begin
          if (commit_hs) begin
            commit_val_q <= 1'b0;
            src_rdy_q <= 1'b1;
            state <= DRAIN_IDLE;
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_tmp_buf_drain.sv
// Scoreboard bench for tcp_rx_tmp_buf_drain: stimulus queues expected
// reads, beats and commits; a negedge monitor pops and compares them.
module tb_tcp_rx_tmp_buf_drain;
  import tcp_rx_tmp_buf_drain_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic src_drain_req_val = 1'b0;
  rx_store_buf_q_struct src_drain_req = '0;
  logic [RX_TMP_BUF_SLAB_NUM_W-1:0] src_drain_req_slab = '0;
  logic drain_src_req_rdy;
  logic drain_mem_rd_en;
  logic [RX_TMP_BUF_MEM_ADDR_W-1:0] drain_mem_rd_addr;
  logic [MAC_INTERFACE_W-1:0] mem_drain_rd_data = '0;
  logic drain_dst_wr_val;
  logic [PAYLOAD_ENTRY_ADDR_W-1:0] drain_dst_wr_addr;
  logic [MAC_INTERFACE_W-1:0] drain_dst_wr_data;
  logic drain_dst_wr_last;
  logic [MAC_PAD_W-1:0] drain_dst_wr_padbytes;
  logic dst_drain_wr_rdy = 1'b1;
  logic drain_slab_free_val;
  logic [RX_TMP_BUF_SLAB_NUM_W-1:0] drain_slab_free_num;
  logic drain_commit_val;
  logic [RX_DRAIN_COMMIT_STRUCT_W-1:0] drain_commit;
  logic state_drain_commit_rdy = 1'b1;

  typedef struct packed {
    logic [31:0]  addr;
    logic [511:0] data;
    logic         last;
    logic [5:0]   pad;
  } beat_t;

  typedef struct {
    rx_drain_commit_struct c;
    logic                  slab;
  } cm_t;

  int    exp_rd[$];
  beat_t exp_beats[$];
  cm_t   exp_cm[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    outstanding = 0;
  int    beats_seen = 0;
  bit    pat_en = 1'b0;
  bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int    pidx = 0;
  int    rd_exp;
  beat_t b;

  tcp_rx_tmp_buf_drain dut (
    .clk                    (clk),
    .rst                    (rst),
    .src_drain_req_val      (src_drain_req_val),
    .src_drain_req          (src_drain_req),
    .src_drain_req_slab     (src_drain_req_slab),
    .drain_src_req_rdy      (drain_src_req_rdy),
    .drain_mem_rd_en        (drain_mem_rd_en),
    .drain_mem_rd_addr      (drain_mem_rd_addr),
    .mem_drain_rd_data      (mem_drain_rd_data),
    .drain_dst_wr_val       (drain_dst_wr_val),
    .drain_dst_wr_addr      (drain_dst_wr_addr),
    .drain_dst_wr_data      (drain_dst_wr_data),
    .drain_dst_wr_last      (drain_dst_wr_last),
    .drain_dst_wr_padbytes  (drain_dst_wr_padbytes),
    .dst_drain_wr_rdy       (dst_drain_wr_rdy),
    .drain_slab_free_val    (drain_slab_free_val),
    .drain_slab_free_num    (drain_slab_free_num),
    .drain_commit_val       (drain_commit_val),
    .drain_commit           (drain_commit),
    .state_drain_commit_rdy (state_drain_commit_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] line_data(input int a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'(a) * 32'h0100_0193 + 32'(i);
    return d;
  endfunction

  // Temp RAM model: one-cycle read latency.
  always @(posedge clk)
    mem_drain_rd_data <= drain_mem_rd_en ? line_data(int'(drain_mem_rd_addr)) : '0;

  task automatic check(input string name, input bit ok,
                       input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_eq(input string name, input logic [575:0] act,
                          input logic [575:0] exp);
    check(name, act === exp, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (drain_mem_rd_en) begin
        if (exp_rd.size() == 0) check("unexpected_rd", 1'b0, drain_mem_rd_addr, 0);
        else begin
          rd_exp = exp_rd.pop_front();
          check_eq("rd_addr", drain_mem_rd_addr, rd_exp);
        end
      end
      outstanding += int'(drain_mem_rd_en) - int'(drain_dst_wr_val && dst_drain_wr_rdy);
      if (drain_mem_rd_en) check("outstanding", outstanding <= 2, outstanding, 2);
      if (drain_dst_wr_val && dst_drain_wr_rdy) begin
        beats_seen++;
        if (exp_beats.size() == 0) check("unexpected_beat", 1'b0, drain_dst_wr_addr, 0);
        else begin
          b = exp_beats.pop_front();
          check_eq("beat_addr", drain_dst_wr_addr, b.addr);
          check_eq("beat_data", drain_dst_wr_data, b.data);
          check_eq("beat_last", drain_dst_wr_last, b.last);
          check_eq("beat_pad", drain_dst_wr_padbytes, b.pad);
        end
      end
      if (drain_commit_val) begin
        check_eq("src_rdy_in_commit", drain_src_req_rdy, 0);
        if (exp_cm.size() == 0) check("unexpected_commit", 1'b0, drain_commit, 0);
        else begin
          check_eq("commit", drain_commit, exp_cm[0].c);
          if (state_drain_commit_rdy) begin
            check_eq("free", {drain_slab_free_val, drain_slab_free_num},
                     {1'b1, exp_cm[0].slab});
            void'(exp_cm.pop_front());
          end
        end
      end
      if (drain_slab_free_val && !(drain_commit_val && state_drain_commit_rdy))
        check("spurious_free", 1'b0, 1, 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (pat_en) begin
      dst_drain_wr_rdy = pat[pidx];
      pidx = (pidx + 1) % 4;
    end
  end

  task automatic issue(input logic slab, input logic [7:0] fid, input logic acc,
                       input logic [31:0] addr, input logic [15:0] len);
    bit ok;
    int lines, pad, n;
    ok = acc && len != 0 && len <= 16'd9152;
    lines = (int'(len) + 63) / 64;
    pad = lines * 64 - int'(len);
    if (ok) for (int k = 0; k < lines; k++) begin
      exp_rd.push_back(int'(slab) * 143 + k);
      exp_beats.push_back('{addr: addr + 32'(k * 64),
                            data: line_data(int'(slab) * 143 + k),
                            last: (k == lines - 1),
                            pad: (k == lines - 1) ? 6'(pad) : 6'd0});
    end
    exp_cm.push_back('{c: '{flowid: fid, accepted: ok, payload_len: len}, slab: slab});
    @(posedge clk); #1;
    src_drain_req = '{flowid: fid, accept_payload: acc, payload_addr: addr, payload_len: len};
    src_drain_req_slab = slab;
    src_drain_req_val = 1'b1;
    n = 0;
    @(negedge clk);
    while (!drain_src_req_rdy && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("req_timeout", 1'b0, 0, 1);
    @(posedge clk); #1;
    src_drain_req_val = 1'b0;
    @(negedge clk);
    if (ok) check_eq("first_rd_en", drain_mem_rd_en, 1);
    else check_eq("drop_commit_val", drain_commit_val, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_cm.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check_eq("seg_done", exp_cm.size(), 0);
    check_eq("seg_leftover", exp_rd.size() + exp_beats.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq(name, {drain_src_req_rdy, drain_mem_rd_en, drain_mem_rd_addr,
                    drain_dst_wr_val, drain_dst_wr_addr, drain_dst_wr_last,
                    drain_dst_wr_padbytes, drain_slab_free_val,
                    drain_slab_free_num, drain_commit_val, drain_commit}, 0);
    check_eq({name, "_data"}, drain_dst_wr_data, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_outputs");

    issue(1'b1, 8'h11, 1'b1, 32'h1000, 16'd130);
    wait_done();
    issue(1'b0, 8'h22, 1'b1, 32'h0, 16'd64);
    wait_done();

    pat_en = 1'b1;
    issue(1'b1, 8'h33, 1'b1, 32'h2000, 16'd620);
    wait_done();
    pat_en = 1'b0;
    @(posedge clk); #1 dst_drain_wr_rdy = 1'b1;

    issue(1'b0, 8'h44, 1'b0, 32'h3000, 16'd100);
    wait_done();
    issue(1'b1, 8'h55, 1'b1, 32'h3000, 16'd0);
    wait_done();
    issue(1'b0, 8'h66, 1'b1, 32'h3000, 16'd9153);
    wait_done();
    issue(1'b1, 8'h67, 1'b1, 32'h8000, 16'd9152);
    wait_done();
    issue(1'b0, 8'h77, 1'b1, 32'hFFFF_FFC0, 16'd128);
    wait_done();

    state_drain_commit_rdy = 1'b0;
    issue(1'b1, 8'h88, 1'b1, 32'h4000, 16'd200);
    n = 0;
    while (!drain_commit_val && n < 200) begin @(negedge clk); n++; end
    check_eq("commit_seen", drain_commit_val, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 state_drain_commit_rdy = 1'b1;
    wait_done();

    beats_seen = 0;
    issue(1'b0, 8'h99, 1'b1, 32'h5000, 16'd640);
    n = 0;
    while (beats_seen < 3 && n < 200) begin @(negedge clk); n++; end
    check_eq("beats_before_rst", beats_seen, 3);
    @(posedge clk); #1 rst = 1'b1;
    exp_rd.delete();
    exp_beats.delete();
    exp_cm.delete();
    outstanding = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midop_reset_outputs");
    issue(1'b1, 8'hAA, 1'b1, 32'h6000, 16'd300);
    wait_done();

    repeat (5) @(negedge clk);
    check_eq("queues_empty", exp_rd.size() + exp_beats.size() + exp_cm.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
